// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer: multi-cycle T0..T3 instruction sequencer for the 4-bit core.
// Owns PC and IR, supports free-run, single-step, halt/resume and datapath branching.
// Every output is a register. Phase outputs are loaded from the next-state decode,
// so they always match the state register.
module fetch_exec_sequencer #(
  parameter int unsigned           ADDR_W   = 5,
  parameter int unsigned           OPC_W    = 4,
  parameter logic [OPC_W-1:0]      HALT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step_req,
  input  logic              resume,
  input  logic [OPC_W-1:0]  rom_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [OPC_W-1:0]  ir,
  output logic [1:0]        timing,
  output logic              phase_valid,
  output logic              instr_done,
  output logic              step_ack,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [OPC_W-1:0]  ir_nxt_s;
  logic              step_flag_r;
  logic              step_flag_nxt_s;
  logic              done_nxt_s;
  logic              ack_nxt_s;
  logic [1:0]        timing_nxt_s;
  logic              phase_valid_nxt_s;
  logic              halted_nxt_s;

  // Next-state, PC/IR update and completion pulses for the current phase.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc;
    ir_nxt_s        = ir;
    step_flag_nxt_s = step_flag_r;
    done_nxt_s      = 1'b0;
    ack_nxt_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          // run has priority over a simultaneous step request; no ack owed.
          state_nxt_s = S_T0;
        end else if (step_req) begin
          state_nxt_s     = S_T0;
          step_flag_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_T0: begin
        ir_nxt_s    = rom_data;
        state_nxt_s = S_T1;
      end
      S_T1: begin
        if (ir == HALT_OPC) begin
          // A halted step never completes, so drop its pending ack.
          state_nxt_s     = S_HALT;
          step_flag_nxt_s = 1'b0;
        end else begin
          pc_nxt_s    = pc + PC_ONE;
          state_nxt_s = S_T2;
        end
      end
      S_T2: begin
        if (branch_taken) begin
          pc_nxt_s = branch_target;
        end else begin
          pc_nxt_s = pc;
        end
        state_nxt_s = S_T3;
      end
      S_T3: begin
        done_nxt_s      = 1'b1;
        ack_nxt_s       = step_flag_r;
        step_flag_nxt_s = 1'b0;
        if (run) begin
          state_nxt_s = S_T0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HALT: begin
        if (resume) begin
          // Skip over the halt word so execution continues after it.
          pc_nxt_s    = pc + PC_ONE;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_HALT;
        end
      end
      default: begin
        state_nxt_s     = S_IDLE;
        step_flag_nxt_s = 1'b0;
      end
    endcase
  end

  // Decode the phase outputs from the state that will be entered next.
  always_comb begin
    timing_nxt_s      = 2'd0;
    phase_valid_nxt_s = 1'b0;
    halted_nxt_s      = 1'b0;
    case (state_nxt_s)
      S_T0: begin
        timing_nxt_s      = 2'd0;
        phase_valid_nxt_s = 1'b1;
      end
      S_T1: begin
        timing_nxt_s      = 2'd1;
        phase_valid_nxt_s = 1'b1;
      end
      S_T2: begin
        timing_nxt_s      = 2'd2;
        phase_valid_nxt_s = 1'b1;
      end
      S_T3: begin
        timing_nxt_s      = 2'd3;
        phase_valid_nxt_s = 1'b1;
      end
      S_HALT: begin
        halted_nxt_s = 1'b1;
      end
      default: begin
        timing_nxt_s      = 2'd0;
        phase_valid_nxt_s = 1'b0;
        halted_nxt_s      = 1'b0;
      end
    endcase
  end

  // State, architectural registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      step_flag_r <= 1'b0;
      pc          <= {ADDR_W{1'b0}};
      ir          <= {OPC_W{1'b0}};
      timing      <= 2'd0;
      phase_valid <= 1'b0;
      instr_done  <= 1'b0;
      step_ack    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      step_flag_r <= step_flag_nxt_s;
      pc          <= pc_nxt_s;
      ir          <= ir_nxt_s;
      timing      <= timing_nxt_s;
      phase_valid <= phase_valid_nxt_s;
      instr_done  <= done_nxt_s;
      step_ack    <= ack_nxt_s;
      halted      <= halted_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer with a completion scoreboard:
// each instruction started pushes its expected post-instruction pc, ir and ack,
// and every instr_done pulse pops and compares one entry.
module tb_fetch_exec_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step_req;
  logic       resume;
  logic [3:0] rom_data;
  logic       branch_taken;
  logic [4:0] branch_target;
  logic [4:0] pc;
  logic [3:0] ir;
  logic [1:0] timing;
  logic       phase_valid;
  logic       instr_done;
  logic       step_ack;
  logic       halted;

  typedef struct packed {
    logic [4:0] pc;
    logic [3:0] ir;
    logic       ack;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] rom [32];
  int         total;
  int         passed;

  fetch_exec_sequencer #(.ADDR_W(5), .OPC_W(4), .HALT_OPC(4'hF)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .step_req      (step_req),
    .resume        (resume),
    .rom_data      (rom_data),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .ir            (ir),
    .timing        (timing),
    .phase_valid   (phase_valid),
    .instr_done    (instr_done),
    .step_ack      (step_ack),
    .halted        (halted)
  );

  assign rom_data = rom[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock, sample 1 time unit after the edge, service the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (instr_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_instr_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_pc", {27'd0, pc}, {27'd0, e.pc});
        chk("done_ir", {28'd0, ir}, {28'd0, e.ir});
        chk("done_ack", {31'd0, step_ack}, {31'd0, e.ack});
      end
    end else begin
      chk("ack_without_done", {31'd0, step_ack}, 32'd0);
    end
  endtask

  // One instruction at at_pc; the FSM must enter T0 on the first tick.
  task automatic run_instr(input int at_pc, input bit do_branch, input logic [4:0] tgt,
                           input bit ack);
    exp_t       e;
    logic [4:0] inc;
    inc    = 5'(at_pc + 1);
    e.pc   = do_branch ? tgt : inc;
    e.ir   = rom[at_pc];
    e.ack  = ack;
    sb.push_back(e);
    tick();
    step_req = 1'b0;
    chk("t0_timing", {30'd0, timing}, 32'd0);
    chk("t0_valid", {31'd0, phase_valid}, 32'd1);
    chk("t0_pc", {27'd0, pc}, at_pc);
    // A branch request outside T2 must be ignored.
    branch_taken  = 1'b1;
    branch_target = 5'd7;
    tick();
    branch_taken = 1'b0;
    chk("t1_timing", {30'd0, timing}, 32'd1);
    chk("t1_ir", {28'd0, ir}, {28'd0, rom[at_pc]});
    chk("t1_pc", {27'd0, pc}, at_pc);
    tick();
    chk("t2_timing", {30'd0, timing}, 32'd2);
    chk("t2_pc", {27'd0, pc}, {27'd0, inc});
    branch_taken  = do_branch;
    branch_target = tgt;
    tick();
    branch_taken = 1'b0;
    chk("t3_timing", {30'd0, timing}, 32'd3);
    chk("t3_pc", {27'd0, pc}, {27'd0, e.pc});
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < 32; i++) rom[i] = 4'((i % 14) + 1);
    rom[4] = 4'hF;
    reset = 1'b1; run = 1'b0; step_req = 1'b0; resume = 1'b0;
    branch_taken = 1'b0; branch_target = 5'd0;

    // Reset state.
    tick();
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_ir", {28'd0, ir}, 32'd0);
    chk("rst_timing", {30'd0, timing}, 32'd0);
    chk("rst_valid", {31'd0, phase_valid}, 32'd0);
    chk("rst_done", {31'd0, instr_done}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Free run 0..2, branch at 3 to 12, then run through 31 and wrap to 0..3.
    reset = 1'b0;
    run   = 1'b1;
    for (int k = 0; k < 3; k++) run_instr(k, 1'b0, 5'd0, 1'b0);
    run_instr(3, 1'b1, 5'd12, 1'b0);
    for (int k = 12; k < 32; k++) run_instr(k, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 4; k++) run_instr(k, 1'b0, 5'd0, 1'b0);

    // Halt word at 4: no completion, pc holds, run alone cannot leave.
    tick();
    chk("h_t0_pc", {27'd0, pc}, 32'd4);
    tick();
    chk("h_t1_ir", {28'd0, ir}, 32'hF);
    tick();
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_pc", {27'd0, pc}, 32'd4);
    chk("h_valid", {31'd0, phase_valid}, 32'd0);
    chk("h_timing", {30'd0, timing}, 32'd0);
    tick();
    tick();
    chk("h_stays", {31'd0, halted}, 32'd1);
    run    = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("res_halted", {31'd0, halted}, 32'd0);
    chk("res_pc", {27'd0, pc}, 32'd5);
    chk("res_valid", {31'd0, phase_valid}, 32'd0);
    tick();
    chk("idle_holds", {31'd0, phase_valid}, 32'd0);

    // Single step at 5: ack with instr_done 5 clocks after the request, back to IDLE.
    step_req = 1'b1;
    run_instr(5, 1'b0, 5'd0, 1'b1);
    tick();
    chk("step_idle", {31'd0, phase_valid}, 32'd0);
    chk("step_pc", {27'd0, pc}, 32'd6);
    tick();
    chk("step_once", {31'd0, phase_valid}, 32'd0);

    // run and step_req together: run wins, no ack.
    run      = 1'b1;
    step_req = 1'b1;
    run_instr(6, 1'b0, 5'd0, 1'b0);

    // Reset in the middle of T2 of the instruction at 7.
    tick();
    tick();
    tick();
    chk("pre_rst_t2", {30'd0, timing}, 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", {27'd0, pc}, 32'd0);
    chk("mid_rst_ir", {28'd0, ir}, 32'd0);
    chk("mid_rst_timing", {30'd0, timing}, 32'd0);
    chk("mid_rst_valid", {31'd0, phase_valid}, 32'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    run_instr(0, 1'b0, 5'd0, 1'b0);
    run = 1'b0;
    tick();
    chk("end_idle", {31'd0, phase_valid}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
